// File: rtl/useq_pkg.sv
// Shared types and defaults for the useq mailbox FIFO host driver.
package useq_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_CAP, ST_GAP} state_e;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int OCC_W          = $clog2(FIFO_DEPTH_DEF) + 1;
endpackage

// File: rtl/useq_byte_skid.sv
// One-entry valid/ready byte holding register; ready is registered as !full.
module useq_byte_skid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o
);
  logic       full_q, full_d;
  logic       rdy_q;
  logic [7:0] data_q;
  logic       load;

  assign load = in_valid_i && rdy_q;

  // Load only happens while empty, so it never collides with a pop.
  always_comb begin
    full_d = full_q;
    if (out_ready_i) full_d = 1'b0;
    if (load)        full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rdy_q  <= !full_d;
      if (load) data_q <= in_data_i;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;
endmodule

// File: rtl/useq_fifo_host.sv
// Host-side strobe sequencer for the useq mailbox FIFO: paces writes/reads,
// keeps a shadow occupancy and never issues both strobes at once.
module useq_fifo_host
  import useq_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [7:0]                  s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [7:0]                  m_data,
  output logic                        write_fifo,
  output logic                        read_fifo,
  output logic [7:0]                  fifo_in,
  input  logic [7:0]                  fifo_out,
  input  logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] occ
);
  localparam int             OW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OW-1:0]  OCC_MAX = OW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0]  OCC_ONE = OW'(1);
  localparam logic [3:0]     GAP_L   = 4'(GAP_CYCLES);
  localparam state_e         ST_POST = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [7:0]    fin_q, fin_d;

  logic          tx_full, gnt_wr, rx_load, rx_rdy;
  logic [7:0]    tx_buf;
  logic          wr_cand, rd_cand;

  useq_byte_skid u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s_valid),
    .in_ready_o  (s_ready),
    .in_data_i   (s_data),
    .out_valid_o (tx_full),
    .out_ready_i (gnt_wr),
    .out_data_o  (tx_buf)
  );

  useq_byte_skid u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (rx_load),
    .in_ready_o  (rx_rdy),
    .in_data_i   (fifo_out),
    .out_valid_o (m_valid),
    .out_ready_i (m_ready),
    .out_data_o  (m_data)
  );

  assign wr_cand = tx_full && (occ_q < OCC_MAX);
  assign rd_cand = m_ready && !m_valid && rx_rdy && !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    occ_d   = occ_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    fin_d   = fin_q;
    gnt_wr  = 1'b0;
    rx_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rr=1 yields to a competing read; every grant favours the other side next.
        if (wr_cand && !(rd_cand && rr_q)) begin
          gnt_wr  = 1'b1;
          wr_d    = 1'b1;
          fin_d   = tx_buf;
          rr_d    = 1'b1;
          state_d = ST_WR;
        end else if (rd_cand) begin
          rd_d    = 1'b1;
          rr_d    = 1'b0;
          state_d = ST_RD;
        end else if (fifo_empty) begin
          occ_d = '0;
        end
      end
      ST_WR: begin
        if (occ_q < OCC_MAX) occ_d = occ_q + OCC_ONE;
        cnt_d   = '0;
        state_d = ST_POST;
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        rx_load = 1'b1;
        if (occ_q != '0) occ_d = occ_q - OCC_ONE;
        cnt_d   = '0;
        state_d = ST_POST;
      end
      ST_GAP: begin
        if (cnt_q == GAP_L - 4'd1) state_d = ST_IDLE;
        else                       cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      occ_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      occ_q   <= occ_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fin_q   <= fin_d;
    end
  end

  assign write_fifo = wr_q;
  assign read_fifo  = rd_q;
  assign fifo_in    = fin_q;
  assign occ        = occ_q;
endmodule

// File: tb/tb_useq_fifo_host.sv
// Directed + randomized bench for useq_fifo_host against a queue model of the useq FIFO.
module tb_useq_fifo_host;
  localparam int DEPTH = 16;
  localparam int GAP   = 1;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data, fifo_in;
  logic       write_fifo, read_fifo;
  logic [7:0] fout;
  logic       fempty;
  logic [4:0] occ;

  useq_fifo_host #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .write_fifo(write_fifo), .read_fifo(read_fifo), .fifo_in(fifo_in),
    .fifo_out(fout), .fifo_empty(fempty), .occ(occ)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] uq[$];   // useq FIFO contents
  logic [7:0] txq[$];  // bytes accepted from host, not yet strobed out
  logic [7:0] rxq[$];  // bytes popped by read strobes, not yet consumed by host
  int  strq[$];
  bit  rec = 0, seen_strobe = 0, acc = 0;
  int  idle_cnt = 0, rd_age = -1, n_wr = 0, n_rd = 0, n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set before the call; model reacts to strobes at the negedge.
  task automatic step();
    logic [7:0] b;
    acc = s_valid && s_ready;
    if (acc) begin txq.push_back(s_data); n_acc++; end
    if (m_valid && m_ready) begin
      chk("rx_pending", 32'(rxq.size() != 0), 1);
      if (rxq.size() != 0) begin b = rxq.pop_front(); chk("rx_data", 32'(m_data), 32'(b)); end
    end
    @(negedge clk);
    chk("excl", 32'(write_fifo & read_fifo), 0);
    if (write_fifo || read_fifo) begin
      if (seen_strobe) chk("gap", 32'(idle_cnt >= GAP), 1);
      seen_strobe = 1;
      idle_cnt = 0;
      if (rec) strq.push_back(write_fifo ? 1 : 2);
    end else idle_cnt++;
    if (write_fifo) begin
      n_wr++;
      chk("wr_room", 32'(uq.size() < DEPTH - 1), 1);
      chk("wr_src", 32'(txq.size() != 0), 1);
      if (txq.size() != 0) begin b = txq.pop_front(); chk("fifo_in", 32'(fifo_in), 32'(b)); end
      uq.push_back(fifo_in);
    end
    if (read_fifo) begin
      n_rd++;
      chk("rd_avail", 32'(uq.size() != 0), 1);
      if (uq.size() != 0) begin fout = uq.pop_front(); rxq.push_back(fout); end
      rd_age = 0;
    end else if (rd_age >= 0) rd_age++;
    if (rd_age == 2) begin chk("rd_lat", 32'(m_valid), 1); rd_age = -1; end
    fempty = (uq.size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    uq.delete(); txq.delete(); rxq.delete();
    fempty = 1'b1; seen_strobe = 0; rd_age = -1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw0, na0, nr0;
    s_valid = 0; s_data = 0; m_ready = 0; fout = 0; fempty = 1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_wr", 32'(write_fifo), 0);
    chk("rst_rd", 32'(read_fifo), 0);
    chk("rst_mv", 32'(m_valid), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_fin", 32'(fifo_in), 0);
    chk("rst_md", 32'(m_data), 0);
    rst_n = 1'b1;
    chk("rdy_pre", 32'(s_ready), 0);
    step();
    chk("rdy_post", 32'(s_ready), 1);

    // single write
    s_valid = 1; s_data = 8'hA5;
    step(); s_valid = 0;
    chk("wr_lead", 32'(write_fifo), 0);
    step();
    chk("wr_pulse", 32'(write_fifo), 1);
    chk("wr_data", 32'(fifo_in), 32'h A5);
    step();
    chk("wr_end", 32'(write_fifo), 0);
    chk("wr_occ", 32'(occ), 1);
    step();
    chk("wr_gap", 32'(write_fifo | read_fifo), 0);

    // single read of a byte placed by the firmware
    uq.delete(); uq.push_back(8'h3C); fempty = 0; m_ready = 1;
    for (int k = 0; k < 20 && !read_fifo; k++) step();
    chk("rd_seen", 32'(read_fifo), 1);
    step();
    chk("rd_pulse", 32'(read_fifo), 0);
    chk("rd_mv_early", 32'(m_valid), 0);
    step();
    chk("rd_mv", 32'(m_valid), 1);
    chk("rd_md", 32'(m_data), 32'h3C);
    chk("rd_occ", 32'(occ), 0);

    // empty FIFO: pull requests must not produce strobes
    nr0 = n_rd;
    repeat (50) step();
    chk("empty_no_rd", 32'(n_rd - nr0), 0);
    chk("empty_mv", 32'(m_valid), 0);

    // arbitration with both sides always ready
    uq.push_back(8'h10); fempty = 0;
    s_valid = 1; s_data = 8'($urandom); m_ready = 1; rec = 1;
    repeat (60) begin
      step();
      if (acc) s_data = 8'($urandom);
    end
    rec = 0; s_valid = 0;
    chk("arb_count", 32'(strq.size() >= 8), 1);
    for (int i = 1; i < strq.size() && i < 10; i++) chk("arb_alt", 32'(strq[i] != strq[i-1]), 1);

    // fill to the occupancy limit, then let the firmware drain
    do_reset();
    nw0 = n_wr; na0 = n_acc;
    s_valid = 1; s_data = 8'h80;
    for (int k = 0; k < 120; k++) begin
      step();
      if (acc) begin
        if (n_acc - na0 < 16) s_data = 8'(8'h80 + (n_acc - na0));
        else s_valid = 0;
      end
    end
    chk("full_wr", 32'(n_wr - nw0), 15);
    chk("full_acc", 32'(n_acc - na0), 16);
    chk("full_occ", 32'(occ), 15);
    chk("full_rdy", 32'(s_ready), 0);
    uq.delete(); fempty = 1;
    for (int k = 0; k < 20 && (n_wr - nw0) < 16; k++) step();
    chk("full_resume", 32'(n_wr - nw0), 16);
    step(); step();
    chk("full_occ2", 32'(occ), 1);

    // asynchronous reset while a write strobe is high
    s_valid = 1; s_data = 8'h5A;
    for (int k = 0; k < 20 && !write_fifo; k++) begin step(); if (acc) s_valid = 0; end
    s_valid = 0;
    chk("rst_wr_seen", 32'(write_fifo), 1);
    rst_n = 0; #1;
    chk("rst_async_wr", 32'(write_fifo), 0);
    chk("rst_async_occ", 32'(occ), 0);
    chk("rst_async_rdy", 32'(s_ready), 0);
    chk("rst_async_fin", 32'(fifo_in), 0);
    @(negedge clk);
    uq.delete(); txq.delete(); rxq.delete();
    fempty = 1; seen_strobe = 0; rd_age = -1;
    rst_n = 1;
    chk("rel_rdy_pre", 32'(s_ready), 0);
    step();
    chk("rel_rdy_post", 32'(s_ready), 1);
    chk("rel_occ", 32'(occ), 0);

    // randomized traffic with firmware-side draining
    nw0 = n_wr; nr0 = n_rd;
    for (int k = 0; k < 1500; k++) begin
      if (!s_valid || acc) begin
        s_valid = ($urandom_range(0, 2) != 0);
        s_data  = 8'($urandom);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) uq.delete();
      else if (uq.size() > 0 && $urandom_range(0, 19) == 0) void'(uq.pop_front());
      fempty = (uq.size() == 0);
      step();
    end
    chk("rand_wr", 32'(n_wr - nw0 > 50), 1);
    chk("rand_rd", 32'(n_rd - nr0 > 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
